seq_det_ctrl: RTL and testbench

Stream controller for the serial sequence-detector datapath. It accepts parallel words over a valid/ready handshake and serializes them MSB-first, one bit per clock, onto the detector bit line. It runs a configurable pattern matcher of up to PAT_W bits, in overlapping or non-overlapping mode, on the emitted stream and reports a registered one-cycle o_det pulse per match. It sits between a word source (register block or DMA) and downstream detection-event consumers.

---
 rtl/seq_det_pkg.sv | 19 +
 rtl/seq_det_match.sv | 86 ++++++++
 rtl/seq_det_ctrl.sv | 138 +++++++++++++
 tb/tb_seq_det_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and default sizing for the sequence-detector stream controller.
package seq_det_pkg;

    localparam int unsigned WORD_W_DEF = 16;
    localparam int unsigned PAT_W_DEF  = 8;
    localparam int unsigned CNT_W_DEF  = 16;

    // Serializer FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Width of a pattern-length field able to hold 0..pat_w
    function automatic int unsigned len_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// Pattern matcher on the serial stream: history, fill count, compare,
// registered match pulse and optional saturating match counter.
// Counter present only when SEQ_DET_CNT_EN is defined.
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned LEN_W = len_w(PAT_W_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             seq,
    input  logic             seq_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             o_det,
    output logic [CNT_W-1:0] match_cnt
);

    // The incoming bit completes the window, so PAT_W-1 stored bits suffice
    logic [PAT_W-2:0] hist;
    logic [LEN_W-1:0] fill;
    logic [PAT_W-1:0] window_c;
    logic [PAT_W-1:0] mask_c;
    logic [PAT_W:0]   one_hot_c;
    logic [LEN_W:0]   fill_inc_c;
    logic             match_c;

    // Window compare against the low len bits of the pattern
    always_comb begin
        window_c   = {hist, seq};
        one_hot_c  = (PAT_W + 1)'(1) << len;
        mask_c     = PAT_W'(one_hot_c - (PAT_W + 1)'(1));
        fill_inc_c = {1'b0, fill} + (LEN_W + 1)'(1);
        match_c    = seq_valid
                  && (len != '0)
                  && (fill_inc_c >= {1'b0, len})
                  && (((window_c ^ pattern) & mask_c) == '0);
    end

    // History, fill count and match pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            fill  <= '0;
            o_det <= 1'b0;
        end else if (clear) begin
            hist  <= '0;
            fill  <= '0;
            o_det <= 1'b0;
        end else begin
            o_det <= match_c;
            if (seq_valid) begin
                hist <= window_c[PAT_W-2:0];
                if (match_c && !overlap) begin
                    fill <= '0;
                end else if (fill != LEN_W'(PAT_W)) begin
                    fill <= fill + LEN_W'(1);
                end
            end
        end
    end

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating match counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (match_c && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_cnt = cnt;
`else
    assign match_cnt = '0;
`endif

endmodule

// File: rtl/seq_det_ctrl.sv
// Stream controller: accepts words over valid/ready, serializes them MSB-first
// and runs the pattern matcher on the emitted stream.
// Optional match counter enabled by SEQ_DET_CNT_EN.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned PAT_W  = PAT_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_word,
    input  logic [PAT_W-1:0]          cfg_pattern,
    input  logic [len_w(PAT_W)-1:0]   cfg_len,
    input  logic                      cfg_overlap,
    input  logic                      clear,
    output logic                      o_seq,
    output logic                      o_seq_valid,
    output logic                      o_det,
    output logic                      done,
    output logic                      busy,
    output logic [CNT_W-1:0]          match_cnt
);

    localparam int unsigned BIT_W = $clog2(WORD_W);
    localparam int unsigned LEN_W = len_w(PAT_W);

    state_e            state;
    state_e            next_state;
    logic [WORD_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [PAT_W-1:0]  pat_q;
    logic [LEN_W-1:0]  len_q;
    logic              overlap_q;
    logic              load_c;
    logic              cfg_load_c;
    logic              last_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, handshake and load strobes
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        load_c     = 1'b0;
        cfg_load_c = 1'b0;
        last_c     = (bit_cnt == '0);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_c     = 1'b1;
                    cfg_load_c = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                in_ready = last_c;
                if (last_c) begin
                    if (in_valid) begin
                        load_c = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shift register and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load_c) begin
            shift_reg <= in_word;
            bit_cnt   <= BIT_W'(WORD_W - 1);
        end else if (state == SHIFT) begin
            shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt - BIT_W'(1);
        end
    end

    // Config snapshot, taken only when a word is accepted from IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q     <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
        end else if (cfg_load_c) begin
            pat_q     <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
        end
    end

    // Word-complete pulse, aligned with the match pulse of the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state == SHIFT) && last_c;
        end
    end

    assign o_seq       = shift_reg[WORD_W-1];
    assign o_seq_valid = (state == SHIFT);
    assign busy        = (state != IDLE);

    seq_det_match #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .seq       (o_seq),
        .seq_valid (o_seq_valid),
        .pattern   (pat_q),
        .len       (len_q),
        .overlap   (overlap_q),
        .o_det     (o_det),
        .match_cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl.
module tb_seq_det_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic        clear;
    logic        o_seq;
    logic        o_seq_valid;
    logic        o_det;
    logic        done;
    logic        busy;
    logic [15:0] match_cnt;

    int checks = 0;
    int errors = 0;

    logic [47:0] det_tr, done_tr, val_tr, seq_tr, rdy_tr;
    logic [47:0] exp_v;

`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    seq_det_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .clear       (clear),
        .o_seq       (o_seq),
        .o_seq_valid (o_seq_valid),
        .o_det       (o_det),
        .done        (done),
        .busy        (busy),
        .match_cnt   (match_cnt)
    );

    function automatic logic [47:0] seq_exp(input logic [15:0] w);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i] = w[15-i];
        return r;
    endfunction

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Offer one word from IDLE; afterwards scramble cfg to prove it was latched
    task automatic start_word(input logic [15:0] w, input logic [7:0] p,
                              input logic [3:0] l, input logic ov, input bit keep);
        @(negedge clk);
        in_word     = w;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = ov;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        cfg_pattern = ~p;
        cfg_len     = 4'd1;
        cfg_overlap = ~ov;
        if (!keep) in_valid = 1'b0;
    endtask

    // Record outputs for n cycles (cycle 0 = first cycle after acceptance)
    task automatic capture(input int n, input int drop_at, input int clear_at);
        det_tr = '0; done_tr = '0; val_tr = '0; seq_tr = '0; rdy_tr = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            det_tr[c]  = o_det;
            done_tr[c] = done;
            val_tr[c]  = o_seq_valid;
            seq_tr[c]  = o_seq;
            rdy_tr[c]  = in_ready;
            if (c == drop_at) in_valid = 1'b0;
            if (c == clear_at) clear = 1'b1;
            else if (c == clear_at + 1) clear = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; cfg_pattern = '0;
        cfg_len = '0; cfg_overlap = 1'b0; clear = 1'b0;
        #12;
        checks++;
        if ({o_seq, o_seq_valid, o_det, done, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000", {o_seq, o_seq_valid, o_det, done, busy});
        end
        checks++;
        if (match_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", match_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_overlap();
        do_clear();
        start_word(16'b1011011010110110, 8'h0B, 4'd4, 1'b1, 1'b0);
        capture(20, -1, -1);
        exp_v = '0; exp_v[4] = 1'b1; exp_v[7] = 1'b1; exp_v[12] = 1'b1; exp_v[15] = 1'b1;
        checks++;
        if (det_tr !== exp_v) begin errors++; $display("FAIL ovl_det: got %h want %h", det_tr, exp_v); end
        checks++;
        if (done_tr !== 48'h000000010000) begin errors++; $display("FAIL ovl_done: got %h want %h", done_tr, 48'h000000010000); end
        checks++;
        if (val_tr !== 48'h00000000FFFF) begin errors++; $display("FAIL ovl_valid: got %h want %h", val_tr, 48'h00000000FFFF); end
        checks++;
        if (seq_tr !== seq_exp(16'b1011011010110110)) begin
            errors++; $display("FAIL ovl_seq: got %h want %h", seq_tr, seq_exp(16'b1011011010110110));
        end
        checks++;
        if (match_cnt !== (CNT_ON ? 16'd4 : 16'd0)) begin
            errors++; $display("FAIL ovl_cnt: got %0d want %0d", match_cnt, CNT_ON ? 4 : 0);
        end
    endtask

    task automatic test_nonoverlap();
        do_clear();
        start_word(16'b1011011010110110, 8'h0B, 4'd4, 1'b0, 1'b0);
        capture(20, -1, -1);
        exp_v = '0; exp_v[4] = 1'b1; exp_v[12] = 1'b1;
        checks++;
        if (det_tr !== exp_v) begin errors++; $display("FAIL novl_det: got %h want %h", det_tr, exp_v); end
        checks++;
        if (match_cnt !== (CNT_ON ? 16'd2 : 16'd0)) begin
            errors++; $display("FAIL novl_cnt: got %0d want %0d", match_cnt, CNT_ON ? 2 : 0);
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        start_word(16'h0002, 8'h0B, 4'd4, 1'b1, 1'b1);
        in_word = 16'hC000;
        capture(40, 16, -1);
        checks++;
        if (rdy_tr !== 48'h00FF80008000) begin errors++; $display("FAIL b2b_ready: got %h want %h", rdy_tr, 48'h00FF80008000); end
        checks++;
        if (val_tr !== 48'h0000FFFFFFFF) begin errors++; $display("FAIL b2b_valid: got %h want %h", val_tr, 48'h0000FFFFFFFF); end
        checks++;
        if (done_tr !== 48'h000100010000) begin errors++; $display("FAIL b2b_done: got %h want %h", done_tr, 48'h000100010000); end
        checks++;
        if (seq_tr !== 48'h000000034000) begin errors++; $display("FAIL b2b_seq: got %h want %h", seq_tr, 48'h000000034000); end
        checks++;
        if (det_tr !== 48'h000000040000) begin errors++; $display("FAIL b2b_det: got %h want %h", det_tr, 48'h000000040000); end
        checks++;
        if (match_cnt !== (CNT_ON ? 16'd1 : 16'd0)) begin
            errors++; $display("FAIL b2b_cnt: got %0d want %0d", match_cnt, CNT_ON ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid_word();
        do_clear();
        start_word(16'hB100, 8'h0B, 4'd4, 1'b1, 1'b0);
        capture(7, -1, -1);
        checks++;
        if (det_tr !== 48'h000000000010) begin errors++; $display("FAIL rmw_pre_det: got %h want %h", det_tr, 48'h000000000010); end
        checks++;
        if (match_cnt !== (CNT_ON ? 16'd1 : 16'd0)) begin
            errors++; $display("FAIL rmw_pre_cnt: got %0d want %0d", match_cnt, CNT_ON ? 1 : 0);
        end
        @(negedge clk);
        checks++;
        if ({o_seq, o_seq_valid} !== 2'b11) begin errors++; $display("FAIL rmw_bit7: got %b want 11", {o_seq, o_seq_valid}); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_seq, o_seq_valid, o_det, done, busy} !== 5'b0 || match_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rmw_async: got %b cnt %0d want 00000 cnt 0", {o_seq, o_seq_valid, o_det, done, busy}, match_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        capture(20, -1, -1);
        checks++;
        if ((det_tr | done_tr | val_tr) !== 48'h0) begin
            errors++; $display("FAIL rmw_quiet: got det %h done %h valid %h want all 0", det_tr, done_tr, val_tr);
        end
        start_word(16'hB000, 8'h0B, 4'd4, 1'b1, 1'b0);
        capture(20, -1, -1);
        checks++;
        if (seq_tr !== seq_exp(16'hB000)) begin errors++; $display("FAIL rmw_next_seq: got %h want %h", seq_tr, seq_exp(16'hB000)); end
        checks++;
        if (det_tr !== 48'h000000000010) begin errors++; $display("FAIL rmw_next_det: got %h want %h", det_tr, 48'h000000000010); end
        checks++;
        if (done_tr !== 48'h000000010000) begin errors++; $display("FAIL rmw_next_done: got %h want %h", done_tr, 48'h000000010000); end
    endtask

    task automatic test_len_bounds();
        do_clear();
        start_word(16'hB6B6, 8'hB6, 4'd0, 1'b1, 1'b0);
        capture(20, -1, -1);
        checks++;
        if (det_tr !== 48'h0) begin errors++; $display("FAIL len0_det: got %h want 0", det_tr); end
        checks++;
        if (done_tr !== 48'h000000010000) begin errors++; $display("FAIL len0_done: got %h want %h", done_tr, 48'h000000010000); end
        do_clear();
        start_word(16'hB6B6, 8'hB6, 4'd8, 1'b1, 1'b0);
        capture(20, -1, -1);
        checks++;
        if (det_tr !== 48'h000000010100) begin errors++; $display("FAIL len8_det: got %h want %h", det_tr, 48'h000000010100); end
        checks++;
        if (match_cnt !== (CNT_ON ? 16'd2 : 16'd0)) begin
            errors++; $display("FAIL len8_cnt: got %0d want %0d", match_cnt, CNT_ON ? 2 : 0);
        end
    endtask

    task automatic test_clear_on_match();
        do_clear();
        start_word(16'hB000, 8'h0B, 4'd4, 1'b1, 1'b0);
        capture(20, -1, -1);
        checks++;
        if (match_cnt !== (CNT_ON ? 16'd1 : 16'd0)) begin
            errors++; $display("FAIL clr_pre_cnt: got %0d want %0d", match_cnt, CNT_ON ? 1 : 0);
        end
        start_word(16'hB000, 8'h0B, 4'd4, 1'b1, 1'b0);
        capture(20, -1, 3);
        checks++;
        if (det_tr !== 48'h0) begin errors++; $display("FAIL clr_det: got %h want 0", det_tr); end
        checks++;
        if (match_cnt !== 16'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", match_cnt); end
        checks++;
        if (done_tr !== 48'h000000010000) begin errors++; $display("FAIL clr_done: got %h want %h", done_tr, 48'h000000010000); end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_back_to_back();
        test_reset_mid_word();
        test_len_bounds();
        test_clear_on_match();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
